mdu_iter: RTL

Iterative integer multiply/divide unit for the execute stage. It sits beside the single-cycle ALU and handles the RV64M operations that ALU cannot: MUL, MULW, DIV/DIVU/REM/REMU and their W forms. It uses a one-bit-per-cycle shift-add multiplier and a restoring divider. Operands and results pass through valid/ready handshakes, so the pipeline stalls while the unit is busy.

---
 rtl/mdu_iter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider
// behind valid/ready handshakes, with single-cycle fast paths for the special cases.
module mdu_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  // state | meaning
  // IDLE  | waiting for an op, in_ready high unless flushing
  // BUSY  | one iteration per cycle; a final cycle applies signs and extension
  // DONE  | result held on the outputs until out_ready

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             mul_r, rem_r, word_r, neg_q_r, neg_r_r;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] x, y, result_r;

  function automatic logic [WIDTH-1:0] sext_w(input logic [WIDTH-1:0] v);
    return {{H{v[H-1]}}, v[H-1:0]};
  endfunction

  logic             is_mul, is_word, is_signed, is_rem, illegal;
  logic [WIDTH-1:0] a_ext, b_ext, mag_a, mag_b, min_val, fast_res, dividend;
  logic             neg_a, neg_b, div_zero, ovf, fast;

  always_comb begin
    is_mul    = (op == 4'd0) || (op == 4'd1);
    is_word   = op inside {4'd1, 4'd6, 4'd7, 4'd8, 4'd9};
    is_signed = op inside {4'd2, 4'd4, 4'd6, 4'd8};
    is_rem    = op inside {4'd4, 4'd5, 4'd8, 4'd9};
    illegal   = op > 4'd9;
    a_ext = a;
    b_ext = b;
    if (is_word) begin
      a_ext = is_signed ? sext_w(a) : {{H{1'b0}}, a[H-1:0]};
      b_ext = is_signed ? sext_w(b) : {{H{1'b0}}, b[H-1:0]};
    end
    neg_a   = is_signed & a_ext[WIDTH-1];
    neg_b   = is_signed & b_ext[WIDTH-1];
    mag_a   = neg_a ? -a_ext : a_ext;
    mag_b   = neg_b ? -b_ext : b_ext;
    // W dividends start in the top half so WIDTH/2 iterations leave the quotient in the low half
    dividend = is_word ? (mag_a << H) : mag_a;
    min_val  = is_word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = is_signed && (a_ext == min_val) && (b_ext == '1);
    fast     = !is_mul && (illegal || div_zero || ovf);
    fast_res = '0;
    if (illegal)       fast_res = '0;
    else if (div_zero) fast_res = is_rem ? a_ext : '1;
    else if (ovf)      fast_res = is_rem ? '0 : a_ext;
    if (is_word) fast_res = sext_w(fast_res);
  end

  logic [WIDTH:0]   mul_acc, shifted, diff;
  logic [WIDTH-1:0] q_fin, r_fin, raw_fin, final_res;

  always_comb begin
    mul_acc   = y[0] ? (acc + {1'b0, x}) : acc;
    shifted   = {acc[WIDTH-1:0], y[WIDTH-1]};
    diff      = shifted - {1'b0, x};
    q_fin     = neg_q_r ? -y : y;
    r_fin     = neg_r_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    raw_fin   = mul_r ? acc[WIDTH-1:0] : (rem_r ? r_fin : q_fin);
    final_res = word_r ? sext_w(raw_fin) : raw_fin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mul_r    <= 1'b0;
      rem_r    <= 1'b0;
      word_r   <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      acc      <= '0;
      x        <= '0;
      y        <= '0;
      result_r <= '0;
    end else if (flush) begin
      state    <= IDLE;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mul_r   <= is_mul;
          rem_r   <= is_rem;
          word_r  <= is_word;
          neg_q_r <= neg_a ^ neg_b;
          neg_r_r <= neg_a;
          acc     <= '0;
          if (fast) begin
            result_r <= fast_res;
            state    <= DONE;
          end else begin
            cnt   <= is_word ? CW'(H) : CW'(WIDTH);
            x     <= is_mul ? a : mag_b;
            y     <= is_mul ? b : dividend;
            state <= BUSY;
          end
        end
        BUSY: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
          if (mul_r) begin
            acc <= mul_acc;
            x   <= x << 1;
            y   <= y >> 1;
          end else if (!diff[WIDTH]) begin
            acc <= diff;
            y   <= {y[WIDTH-2:0], 1'b1};
          end else begin
            acc <= shifted;
            y   <= {y[WIDTH-2:0], 1'b0};
          end
        end else begin
          result_r <= final_res;
          state    <= DONE;
        end
        DONE: if (out_ready) begin
          result_r <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_r;
endmodule
